cook_sequencer: RTL
===================

COOK_SEQUENCER -- requirements
Module: cook_sequencer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100, clk cycles per second.
REQ-002 SHALL have parameter BEEP_SECS, default 3, seconds of end-of-cook beep.
REQ-003 SHALL have port clk  in  1  single clock, all flops rising-edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port keypad  in  10  one-hot digit keys, bit k = digit k.
REQ-006 SHALL have ports startn, stopn, clearn  in  1 each  active-low buttons.
REQ-007 SHALL have port door_closed  in  1  1 = door closed.
REQ-008 SHALL have port timer_zero  in  1  countdown timer reads 0:00.
REQ-009 SHALL have port load  out  1  one-cycle pulse: timer loads load_mins/load_tens/load_ones.
REQ-010 SHALL have ports load_mins, load_tens, load_ones  out  4 each  BCD entry register.
REQ-011 SHALL have port timer_clear  out  1  one-cycle pulse: timer to 0:00.
REQ-012 SHALL have port sec_tick  out  1  one-cycle pulse per second while cooking.
REQ-013 SHALL have ports mag_on  out  1  magnetron enable; beep  out  1  alarm; state  out  3  debug.

Function
REQ-014 States SHALL be IDLE, SET, COOK, PAUSE, DONE.
REQ-015 All button, door and keypad inputs SHALL pass a 2-flop synchronizer; buttons/keys act on press edge (high-to-low for buttons, zero-to-one-hot for keypad), state updating no later than the 3rd clk edge after input change.
REQ-016 Keypad values with zero or more than one bit set SHALL be ignored.
REQ-017 Digit press in IDLE or SET: ones->tens, tens->mins, new digit->ones, old mins discarded; IDLE->SET; no validation (tens up to 9 passed raw).
REQ-018 Digits SHALL be ignored in COOK, PAUSE, DONE.
REQ-019 Event priority per cycle: clear > timer_zero > (stop or door open) > start > digit.
REQ-020 clear in any state SHALL zero entry register, pulse timer_clear, go IDLE.
REQ-021 SET + start + door_closed + entry nonzero: pulse load, reset prescaler, go COOK; otherwise start ignored (state held).
REQ-022 COOK: prescaler counts 0..TICKS_PER_SEC-1, sec_tick pulses on wrap.
REQ-023 COOK + timer_zero: go DONE, zero entry register.
REQ-024 COOK + (stop press or door_closed low): go PAUSE; prescaler holds value.
REQ-025 PAUSE + start + door_closed: go COOK, no load pulse, prescaler resumes held value; start with door open ignored.
REQ-026 mag_on SHALL equal (state==COOK) AND synchronized door_closed AND raw door_closed, so door opening drops mag_on combinationally.
REQ-027 DONE: beep=1, prescaler counts BEEP_SECS*TICKS_PER_SEC cycles then IDLE; any button press or door opening ends DONE early to IDLE.
REQ-028 sec_tick SHALL be 0 outside COOK; load and timer_clear never both high.

Reset
REQ-029 resetn low SHALL immediately force IDLE, entry 0/0/0, prescaler 0, synchronizers to idle levels (buttons 1, door 0, keypad 0), all pulse outputs, mag_on, beep 0.
REQ-030 Reset mid-COOK SHALL drop mag_on without waiting for clk.
REQ-031 After release, a button held low SHALL NOT register as a press until released and pressed again.

Structure
REQ-032 Package microwave_pkg SHALL hold state encoding (IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4) and default TICKS_PER_SEC/BEEP_SECS constants.
REQ-033 One sub-module btn_sync (2-flop synchronizer + edge pulse, parameterized width) SHALL be instantiated per input group.

Verification
REQ-034 Door open, keys 3,5,9, start -> state SET, no load; close door, start -> one load with 3/5/9, mag_on=1, sec_tick every 100 cycles.
REQ-035 COOK, door opened at 30 ticks -> mag_on 0 same cycle, PAUSE, no sec_tick; close, start -> COOK, no load, next tick after remaining held count.
REQ-036 COOK, stopn low -> PAUSE, mag_on 0; start -> COOK, mag_on 1.
REQ-037 Keys 2,4,5, start, clearn after 30 ticks -> timer_clear pulse, IDLE, entry 0/0/0, mag_on 0.
REQ-038 Keys 1,7,9, start, then timer_zero -> DONE, beep high exactly 300 cycles, then IDLE; keys 1,2,3,4 -> entry 2/3/4; keypad 0x003 -> ignored.
REQ-039 resetn low mid-COOK -> mag_on, beep, sec_tick 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared state encoding, default timing constants and keypad decode helpers
// for the microwave cook sequencer.
package microwave_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSet   = 3'd1,
    StCook  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam int unsigned DefaultTicksPerSec = 100;
  localparam int unsigned DefaultBeepSecs    = 3;

  function automatic logic is_onehot10(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] onehot_to_bcd(input logic [9:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer with a third history flop for press-edge detection.
// Edges are suppressed until the pipeline holds real samples after reset.
module btn_sync #(
  parameter int unsigned       Width     = 1,
  parameter logic [Width-1:0]  IdleLevel = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] level,
  output logic [Width-1:0] prev,
  output logic [Width-1:0] press,
  output logic             valid
);

  logic [Width-1:0] s1_q, s2_q, s3_q;
  logic [2:0]       fill_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q   <= IdleLevel;
      s2_q   <= IdleLevel;
      s3_q   <= IdleLevel;
      fill_q <= 3'b000;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  // An input held active across reset release never looks like a fresh press.
  assign valid = fill_q[2];
  assign level = s2_q;
  assign prev  = s3_q;
  assign press = {Width{valid}} & ~(s3_q ^ IdleLevel) & (s2_q ^ IdleLevel);

endmodule

// File: rtl/cook_sequencer.sv
// Microwave control sequencer: keypad entry, start/stop/clear handling,
// cook prescaler producing second ticks, and end-of-cook beep.
module cook_sequencer
  import microwave_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DefaultTicksPerSec,
  parameter int unsigned BEEP_SECS     = DefaultBeepSecs
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] keypad,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       load,
  output logic [3:0] load_mins,
  output logic [3:0] load_tens,
  output logic [3:0] load_ones,
  output logic       timer_clear,
  output logic       sec_tick,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state
);

  localparam int unsigned BeepCycles = BEEP_SECS * TICKS_PER_SEC;
  localparam int unsigned PreMax     = (BeepCycles > TICKS_PER_SEC) ? BeepCycles : TICKS_PER_SEC;
  localparam int unsigned PW         = $clog2(PreMax + 1);
  localparam logic [PW-1:0] TickLast = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] BeepLast = PW'(BeepCycles - 1);

  logic [2:0] btn_level, btn_prev, btn_press;
  logic       btn_valid;
  logic       door_level, door_prev, door_press, door_valid;
  logic [9:0] key_level, key_prev, key_press;
  logic       key_valid;

  btn_sync #(.Width(3), .IdleLevel(3'b111)) u_btn_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    ({clearn, stopn, startn}),
    .level  (btn_level),
    .prev   (btn_prev),
    .press  (btn_press),
    .valid  (btn_valid)
  );

  btn_sync #(.Width(1), .IdleLevel(1'b0)) u_door_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (door_closed),
    .level  (door_level),
    .prev   (door_prev),
    .press  (door_press),
    .valid  (door_valid)
  );

  btn_sync #(.Width(10), .IdleLevel(10'd0)) u_key_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (keypad),
    .level  (key_level),
    .prev   (key_prev),
    .press  (key_press),
    .valid  (key_valid)
  );

  logic unused_sync;
  assign unused_sync = ^{btn_level, btn_prev, btn_valid, door_prev, door_press, door_valid,
                         key_press};

  logic       start_press, stop_press, clear_press, digit_press;
  logic [3:0] digit;

  assign start_press = btn_press[0];
  assign stop_press  = btn_press[1];
  assign clear_press = btn_press[2];
  // Only a transition from no key to exactly one key counts as a digit.
  assign digit_press = key_valid && (key_prev == 10'd0) && is_onehot10(key_level);
  assign digit       = onehot_to_bcd(key_level);

  state_e        state_q;
  logic [3:0]    mins_q, tens_q, ones_q;
  logic [PW-1:0] presc_q;
  logic          load_q, clr_q, tick_q, beep_q;
  logic          entry_nonzero;

  assign entry_nonzero = (mins_q != 4'd0) || (tens_q != 4'd0) || (ones_q != 4'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      mins_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      presc_q <= '0;
      load_q  <= 1'b0;
      clr_q   <= 1'b0;
      tick_q  <= 1'b0;
      beep_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      clr_q  <= 1'b0;
      tick_q <= 1'b0;
      if (clear_press) begin
        mins_q  <= 4'd0;
        tens_q  <= 4'd0;
        ones_q  <= 4'd0;
        presc_q <= '0;
        clr_q   <= 1'b1;
        beep_q  <= 1'b0;
        state_q <= StIdle;
      end else if (state_q == StCook && timer_zero) begin
        mins_q  <= 4'd0;
        tens_q  <= 4'd0;
        ones_q  <= 4'd0;
        presc_q <= '0;
        beep_q  <= 1'b1;
        state_q <= StDone;
      end else if (state_q == StCook && (stop_press || !door_level)) begin
        state_q <= StPause;
      end else begin
        case (state_q)
          StIdle, StSet: begin
            if (start_press) begin
              if (state_q == StSet && door_level && entry_nonzero) begin
                load_q  <= 1'b1;
                presc_q <= '0;
                state_q <= StCook;
              end
            end else if (digit_press) begin
              mins_q  <= tens_q;
              tens_q  <= ones_q;
              ones_q  <= digit;
              state_q <= StSet;
            end
          end
          StCook: begin
            if (presc_q == TickLast) begin
              presc_q <= '0;
              tick_q  <= 1'b1;
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
          StPause: begin
            if (start_press && door_level) state_q <= StCook;
          end
          StDone: begin
            if (start_press || stop_press || !door_level || presc_q == BeepLast) begin
              presc_q <= '0;
              beep_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign load        = load_q;
  assign load_mins   = mins_q;
  assign load_tens   = tens_q;
  assign load_ones   = ones_q;
  assign timer_clear = clr_q;
  assign sec_tick    = tick_q;
  assign beep        = beep_q;
  assign state       = state_q;
  // Raw door term lets an opening door cut the magnetron before synchronization.
  assign mag_on      = (state_q == StCook) && door_level && door_closed;

endmodule
